// File: rtl/multi_port_router.sv
// multi_port_router: routes DATA_W-bit beats from N_IN inputs to N_OUT outputs,
// with the output chosen by each beat's address field. Every output owns a
// round-robin arbiter and a FIFO_DEPTH-entry FIFO. Outputs honour out_ready.
// Ports:
//   clk, rst_n          clock and synchronous active-low reset
//   reg_*               register interface: CTRL 0x0, OUT_EN 0x1, STATUS 0x2,
//                       DROP_CNT 0x3, and optional per-output counters 0x4+o
//   in_data/in_addr     input beats and their destination output, packed per port
//   in_valid/in_ready   input handshake
//   out_data/out_valid  FIFO head per output; out_data reads 0 while empty
//   out_ready           sink accepts the head
// Build option: define ROUTER_STATS_EN to add per-output delivered-beat counters.

// Per-output lane: this output's round-robin arbiter and its FIFO.
module router_lane #(
  parameter int N_IN       = 2,
  parameter int DATA_W     = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [N_IN-1:0]        req_i,
  input  logic [N_IN*DATA_W-1:0] data_i,
  input  logic                   ready_i,
  output logic [N_IN-1:0]        grant_o,
  output logic [DATA_W-1:0]      data_o,
  output logic                   valid_o,
  output logic                   empty_o,
  output logic                   full_o,
  output logic                   pop_o
);
  localparam int IW = $clog2(N_IN);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;

  logic [IW-1:0]     ptr_q, ptr_d, win;
  logic [DATA_W-1:0] mem_q [FIFO_DEPTH];
  logic [PW-1:0]     wr_q, rd_q;
  logic [CW-1:0]     cnt_q;
  logic              push;

  assign full_o  = (cnt_q == CW'(FIFO_DEPTH));
  assign empty_o = (cnt_q == '0);
  assign valid_o = !empty_o;
  assign pop_o   = valid_o & ready_i;
  assign data_o  = valid_o ? mem_q[rd_q] : '0;

  // The search starts at ptr_q and wraps. A full FIFO blocks every grant, even
  // when a pop is pending this cycle, so a beat never passes straight through.
  always_comb begin
    int idx;
    idx     = 0;
    grant_o = '0;
    win     = '0;
    push    = 1'b0;
    for (int k = 0; k < N_IN; k++) begin
      idx = (int'(ptr_q) + k) % N_IN;
      if (!push && req_i[idx] && !full_o) begin
        grant_o[idx] = 1'b1;
        win          = IW'(idx);
        push         = 1'b1;
      end
    end
    ptr_d = push ? IW'((int'(win) + 1) % N_IN) : ptr_q;
  end

  always_ff @(posedge clk)
    if (push) mem_q[wr_q] <= data_i[win*DATA_W +: DATA_W];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ptr_q <= '0;
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      ptr_q <= ptr_d;
      if (push) wr_q <= wr_q + 1'b1;
      if (pop_o) rd_q <= rd_q + 1'b1;
      case ({push, pop_o})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end
endmodule

module multi_port_router #(
  parameter int N_IN       = 2,
  parameter int N_OUT      = 4,
  parameter int DATA_W     = 8,
  parameter int REG_W      = 32,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic [3:0]                      reg_addr,
  input  logic [REG_W-1:0]                reg_wdata,
  input  logic                            reg_en,
  input  logic                            reg_we,
  output logic [REG_W-1:0]                reg_rdata,
  input  logic [N_IN*DATA_W-1:0]          in_data,
  input  logic [N_IN*$clog2(N_OUT)-1:0]   in_addr,
  input  logic [N_IN-1:0]                 in_valid,
  output logic [N_IN-1:0]                 in_ready,
  output logic [N_OUT*DATA_W-1:0]         out_data,
  output logic [N_OUT-1:0]                out_valid,
  input  logic [N_OUT-1:0]                out_ready
);
  localparam int AW  = $clog2(N_OUT);
  localparam int DCW = $clog2(N_IN + 1);

  logic                         en_q;
  logic [N_OUT-1:0]             out_en_q;
  logic [REG_W-1:0]             drop_q, drop_d, rdata_q, rdata_d;
  logic [N_OUT-1:0][N_IN-1:0]   req, grant;
  logic [N_IN-1:0]              drop;
  logic [N_OUT-1:0]             empty, full, pop;
  logic [DCW-1:0]               drop_n;
  logic [REG_W:0]               drop_sum;
  logic                         wr;
  logic                         unused_ok;

  assign wr        = reg_en & reg_we;
  assign reg_rdata = rdata_q;
  assign unused_ok = ^{reg_wdata, pop};

  // An address beyond N_OUT-1 (possible when N_OUT is not a power of 2) hits
  // no output and is treated like a disabled output, so the beat is dropped.
  always_comb begin
    logic [AW-1:0] a;
    logic          oen;
    a    = '0;
    oen  = 1'b0;
    req  = '0;
    drop = '0;
    for (int i = 0; i < N_IN; i++) begin
      a   = in_addr[i*AW +: AW];
      oen = 1'b0;
      for (int o = 0; o < N_OUT; o++) begin
        if (int'(a) == o) oen = out_en_q[o];
        if (en_q && in_valid[i] && int'(a) == o && out_en_q[o]) req[o][i] = 1'b1;
      end
      drop[i] = en_q & in_valid[i] & !oen;
    end
  end

  always_comb begin
    in_ready = '0;
    for (int i = 0; i < N_IN; i++) begin
      in_ready[i] = drop[i];
      for (int o = 0; o < N_OUT; o++) in_ready[i] = in_ready[i] | grant[o][i];
      in_ready[i] = in_ready[i] & rst_n;
    end
  end

  for (genvar o = 0; o < N_OUT; o++) begin : g_lane
    router_lane #(.N_IN(N_IN), .DATA_W(DATA_W), .FIFO_DEPTH(FIFO_DEPTH)) u_lane (
      .clk     (clk),
      .rst_n   (rst_n),
      .req_i   (req[o]),
      .data_i  (in_data),
      .ready_i (out_ready[o]),
      .grant_o (grant[o]),
      .data_o  (out_data[o*DATA_W +: DATA_W]),
      .valid_o (out_valid[o]),
      .empty_o (empty[o]),
      .full_o  (full[o]),
      .pop_o   (pop[o])
    );
  end

  // Several inputs can drop in the same cycle, so the counter adds a popcount.
  // A clear write wins over any increment in that cycle.
  always_comb begin
    drop_n = '0;
    for (int i = 0; i < N_IN; i++) drop_n = drop_n + DCW'(drop[i]);
    drop_sum = {1'b0, drop_q} + (REG_W+1)'(drop_n);
    if (wr && reg_addr == 4'h3) drop_d = '0;
    else if (drop_sum[REG_W])   drop_d = '1;
    else                        drop_d = drop_sum[REG_W-1:0];
  end

`ifdef ROUTER_STATS_EN
  logic [REG_W-1:0] stat_q [N_OUT];

  always_ff @(posedge clk) begin
    for (int o = 0; o < N_OUT; o++) begin
      if (!rst_n)                                stat_q[o] <= '0;
      else if (wr && reg_addr == 4'(4 + o))      stat_q[o] <= '0;
      else if (pop[o] && stat_q[o] != '1)        stat_q[o] <= stat_q[o] + 1'b1;
    end
  end
`endif

  always_comb begin
    rdata_d = '0;
    case (reg_addr)
      4'h0: rdata_d[0] = en_q;
      4'h1: rdata_d[N_OUT-1:0] = out_en_q;
      4'h2: begin
        rdata_d[N_OUT-1:0]  = empty;
        rdata_d[8 +: N_OUT] = full;
      end
      4'h3: rdata_d = drop_q;
      default: begin
`ifdef ROUTER_STATS_EN
        for (int o = 0; o < N_OUT; o++)
          if (reg_addr == 4'(4 + o)) rdata_d = stat_q[o];
`endif
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      en_q     <= 1'b1;
      out_en_q <= '1;
      drop_q   <= '0;
      rdata_q  <= '0;
    end else begin
      if (wr && reg_addr == 4'h0) en_q <= reg_wdata[0];
      if (wr && reg_addr == 4'h1) out_en_q <= reg_wdata[N_OUT-1:0];
      drop_q <= drop_d;
      if (reg_en && !reg_we) rdata_q <= rdata_d;
    end
  end
endmodule
